control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port instr  input  32  instruction word; opcode = instr[31:26], func = instr[4:0].
REQ-004 SHALL have port instr_valid  input  1  instr is valid this cycle.
REQ-005 SHALL have port fetch_req  output  1  sequencer waiting for an instruction.
REQ-006 SHALL have port halt  output  1  sequencer halted.
REQ-007 SHALL have 1-bit outputs RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl, ShortBr, LongBr, MemRead, MemWrite, BranchReg: datapath control strobes and selects.
REQ-008 SHALL have 2-bit outputs ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg: datapath control selects.

Function
REQ-009 SHALL use states FETCH, DECODE, EXEC, MEM, WB, HALT, all registered.
REQ-010 FETCH SHALL drive fetch_req=1 and all controls=0; stay in FETCH while instr_valid=0; on instr_valid=1 latch instr and go to DECODE.
REQ-011 instr SHALL be sampled only in FETCH with instr_valid=1; changes in any other state are ignored.
REQ-012 DECODE SHALL register the decoded control bundle, drive all controls 0, and go to EXEC; controls hold from EXEC until the state returns to FETCH.
REQ-013 EXEC SHALL go to MEM for lw/sw, WB for register-writing ops, FETCH for branches without link, and HALT for opcode 63.
REQ-014 MemRead (lw) / MemWrite (sw) SHALL be high only in MEM, for exactly 1 cycle; MEM goes to WB for lw and FETCH for sw.
REQ-015 RegWrite SHALL be high only in WB, for exactly 1 cycle; WB goes to FETCH.
REQ-016 Decode: opcode 0 is R-type with ALUSrc=0; func 0 add ALUOp=01; func 1 comp ALUOp=01, CompEnbl=1; func 2 and ALUOp=10; func 3 xor ALUOp=11; func 4/5/6 shift ShiftEnbl=1, ShiftAmntSel=1, ShiftType=func-4.
REQ-017 Decode: opcode 1 addi ALUSrc=1, ALUOp=01; opcode 2 compi as addi plus CompEnbl=1; opcode 4 lw ALUSrc=1, ImmSel=1, ALUOp=01, MemToReg=01; opcode 5 sw as lw but MemToReg=00 and no WB.
REQ-018 Decode: opcode 6 br BranchReg=1, JumpType=01; opcode 7 b LongBr=1, JumpType=01; opcode 8 short branch ShortBr=1, BranchType=func[1:0]; opcode 9 bl LongBr=1, JumpType=10, RegDst=10, MemToReg=10, WB.
REQ-019 Unlisted decode fields SHALL be 0; RegDst=00 except for bl.
REQ-020 Latency (sampling edge = 0): ALU op WB in cycle 3; lw MEM in cycle 3 and WB in cycle 4; branch EXEC in cycle 2; fetch_req high again in cycle 4 (ALU), 5 (lw), 3 (branch).
REQ-021 HALT SHALL drive halt=1, fetch_req=0, all controls 0, and be left only by rst.
REQ-022 Illegal opcode or R-type func 7..31 without the macro SHALL be a NOP: no controls asserted, EXEC goes to FETCH.

Reset
REQ-023 rst=1 SHALL immediately force state FETCH, latched instr 0, all controls 0, halt=0, fetch_req=1, including mid-MEM or mid-WB (an in-flight write strobe drops asynchronously).
REQ-024 After rst deasserts, the first instr_valid sample SHALL occur on the first rising edge.

Configuration
REQ-025 Macro CTRL_ILLEGAL_HALT_EN: when defined, an illegal opcode/func SHALL take EXEC to HALT (halt=1); when undefined, REQ-022 applies.

Verification
REQ-026 instr opcode 1 (addi), instr_valid 1 cycle -> ALUSrc=1, ALUOp=01 in cycles 2-3; RegWrite=1 only in cycle 3; fetch_req=1 in cycle 4.
REQ-027 opcode 0 func 1 (comp), then opcode 0 func 3 (xor) back-to-back -> CompEnbl=1/ALUOp=01 for the first; ALUOp=11/CompEnbl=0 for the second; exactly one RegWrite pulse each.
REQ-028 opcode 4 (lw) -> MemRead=1 only in cycle 3, RegWrite=1 only in cycle 4, MemToReg=01; opcode 5 (sw) -> MemWrite=1 in cycle 3, never RegWrite.
REQ-029 opcode 9 (bl) -> LongBr=1, JumpType=10, RegDst=10, RegWrite in cycle 3; opcode 8 func 2 -> ShortBr=1, BranchType=10, no RegWrite.
REQ-030 rst asserted in the WB cycle of addi -> RegWrite falls in the same cycle, fetch_req=1; opcode 63 -> halt=1 persists for 10 cycles despite instr_valid=1.
REQ-031 opcode 0 func 9 -> NOP with the macro undefined, halt=1 with the macro defined.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer driving datapath strobes and selects.
// Define CTRL_ILLEGAL_HALT_EN to make illegal opcodes/funcs halt instead of executing as NOPs.
module control_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        fetch_req,
   output logic        halt,
   output logic        RegWrite,
   output logic        ImmSel,
   output logic        ALUSrc,
   output logic        CompEnbl,
   output logic        ShiftAmntSel,
   output logic        ShiftEnbl,
   output logic        ShortBr,
   output logic        LongBr,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        BranchReg,
   output logic [1:0]  ALUOp,
   output logic [1:0]  RegDst,
   output logic [1:0]  ShiftType,
   output logic [1:0]  BranchType,
   output logic [1:0]  JumpType,
   output logic [1:0]  MemToReg
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   typedef enum logic [1:0] {GO_FETCH, GO_MEM, GO_WB, GO_HALT} route_t;

   typedef struct packed {
      logic       imm_sel;
      logic       alu_src;
      logic       comp_enbl;
      logic       shift_amnt_sel;
      logic       shift_enbl;
      logic       short_br;
      logic       long_br;
      logic       branch_reg;
      logic [1:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] shift_type;
      logic [1:0] branch_type;
      logic [1:0] jump_type;
      logic [1:0] mem_to_reg;
      logic       mem_rd;
      logic       mem_wr;
      route_t     route;
   } ctrl_t;

`ifdef CTRL_ILLEGAL_HALT_EN
   localparam route_t ILLEGAL_ROUTE = GO_HALT;
`else
   localparam route_t ILLEGAL_ROUTE = GO_FETCH;
`endif

   state_t      state, state_nxt;
   logic [31:0] instr_q;
   ctrl_t       ctrl_q, dec;
   logic        show_ctrl;
   logic [5:0]  opcode;
   logic [4:0]  func;
   logic        unused_bits;

   assign opcode      = instr_q[31:26];
   assign func        = instr_q[4:0];
   assign unused_bits = ^instr_q[25:5];

   always_comb begin
      dec       = '0;
      dec.route = GO_FETCH;
      case (opcode)
         6'd0: begin
            dec.route = GO_WB;
            case (func)
               5'd0: dec.alu_op = 2'b01;
               5'd1: begin
                  dec.alu_op    = 2'b01;
                  dec.comp_enbl = 1'b1;
               end
               5'd2: dec.alu_op = 2'b10;
               5'd3: dec.alu_op = 2'b11;
               5'd4, 5'd5, 5'd6: begin
                  dec.shift_enbl     = 1'b1;
                  dec.shift_amnt_sel = 1'b1;
                  // func 4/5/6 maps to shift type 0/1/2 via its low two bits
                  dec.shift_type     = func[1:0];
               end
               default: begin
                  dec       = '0;
                  dec.route = ILLEGAL_ROUTE;
               end
            endcase
         end
         6'd1, 6'd2: begin
            dec.alu_src   = 1'b1;
            dec.alu_op    = 2'b01;
            dec.comp_enbl = (opcode == 6'd2);
            dec.route     = GO_WB;
         end
         6'd4, 6'd5: begin
            dec.alu_src    = 1'b1;
            dec.imm_sel    = 1'b1;
            dec.alu_op     = 2'b01;
            dec.mem_rd     = (opcode == 6'd4);
            dec.mem_wr     = (opcode == 6'd5);
            dec.mem_to_reg = (opcode == 6'd4) ? 2'b01 : 2'b00;
            dec.route      = GO_MEM;
         end
         6'd6: begin
            dec.branch_reg = 1'b1;
            dec.jump_type  = 2'b01;
         end
         6'd7: begin
            dec.long_br   = 1'b1;
            dec.jump_type = 2'b01;
         end
         6'd8: begin
            dec.short_br    = 1'b1;
            dec.branch_type = func[1:0];
         end
         6'd9: begin
            dec.long_br    = 1'b1;
            dec.jump_type  = 2'b10;
            dec.reg_dst    = 2'b10;
            dec.mem_to_reg = 2'b10;
            dec.route      = GO_WB;
         end
         6'd63:   dec.route = GO_HALT;
         default: dec.route = ILLEGAL_ROUTE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr_q <= '0;
         ctrl_q  <= '0;
      end else begin
         if (state == FETCH && instr_valid) instr_q <= instr;
         if (state == DECODE) ctrl_q <= dec;
      end
   end

   // Strobes are decoded from state so reset drops them without waiting for a clock.
   always_comb begin
      state_nxt = state;
      fetch_req = 1'b0;
      halt      = 1'b0;
      show_ctrl = 1'b0;
      RegWrite  = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      case (state)
         FETCH: begin
            fetch_req = 1'b1;
            if (instr_valid) state_nxt = DECODE;
         end
         DECODE: state_nxt = EXEC;
         EXEC: begin
            show_ctrl = 1'b1;
            case (ctrl_q.route)
               GO_MEM:  state_nxt = MEM;
               GO_WB:   state_nxt = WB;
               GO_HALT: state_nxt = HALT;
               default: state_nxt = FETCH;
            endcase
         end
         MEM: begin
            show_ctrl = 1'b1;
            MemRead   = ctrl_q.mem_rd;
            MemWrite  = ctrl_q.mem_wr;
            state_nxt = ctrl_q.mem_rd ? WB : FETCH;
         end
         WB: begin
            show_ctrl = 1'b1;
            RegWrite  = 1'b1;
            state_nxt = FETCH;
         end
         HALT:    halt = 1'b1;
         default: state_nxt = FETCH;
      endcase
   end

   assign ImmSel       = show_ctrl & ctrl_q.imm_sel;
   assign ALUSrc       = show_ctrl & ctrl_q.alu_src;
   assign CompEnbl     = show_ctrl & ctrl_q.comp_enbl;
   assign ShiftAmntSel = show_ctrl & ctrl_q.shift_amnt_sel;
   assign ShiftEnbl    = show_ctrl & ctrl_q.shift_enbl;
   assign ShortBr      = show_ctrl & ctrl_q.short_br;
   assign LongBr       = show_ctrl & ctrl_q.long_br;
   assign BranchReg    = show_ctrl & ctrl_q.branch_reg;
   assign ALUOp        = show_ctrl ? ctrl_q.alu_op      : 2'b00;
   assign RegDst       = show_ctrl ? ctrl_q.reg_dst     : 2'b00;
   assign ShiftType    = show_ctrl ? ctrl_q.shift_type  : 2'b00;
   assign BranchType   = show_ctrl ? ctrl_q.branch_type : 2'b00;
   assign JumpType     = show_ctrl ? ctrl_q.jump_type   : 2'b00;
   assign MemToReg     = show_ctrl ? ctrl_q.mem_to_reg  : 2'b00;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes expected per-cycle output vectors,
// a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_req, halt;
   logic        RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl;
   logic        ShortBr, LongBr, MemRead, MemWrite, BranchReg;
   logic [1:0]  ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .fetch_req(fetch_req), .halt(halt),
      .RegWrite(RegWrite), .ImmSel(ImmSel), .ALUSrc(ALUSrc), .CompEnbl(CompEnbl),
      .ShiftAmntSel(ShiftAmntSel), .ShiftEnbl(ShiftEnbl), .ShortBr(ShortBr), .LongBr(LongBr),
      .MemRead(MemRead), .MemWrite(MemWrite), .BranchReg(BranchReg),
      .ALUOp(ALUOp), .RegDst(RegDst), .ShiftType(ShiftType), .BranchType(BranchType),
      .JumpType(JumpType), .MemToReg(MemToReg)
   );

   typedef struct packed {
      logic       fetch_req;
      logic       halt;
      logic       reg_write;
      logic       imm_sel;
      logic       alu_src;
      logic       comp_enbl;
      logic       shift_amnt_sel;
      logic       shift_enbl;
      logic       short_br;
      logic       long_br;
      logic       mem_read;
      logic       mem_write;
      logic       branch_reg;
      logic [1:0] alu_op;
      logic [1:0] reg_dst;
      logic [1:0] shift_type;
      logic [1:0] branch_type;
      logic [1:0] jump_type;
      logic [1:0] mem_to_reg;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   function automatic obs_t idle_vec();
      obs_t v = '0;
      v.fetch_req = 1'b1;
      return v;
   endfunction

   function automatic obs_t halt_vec();
      obs_t v = '0;
      v.halt = 1'b1;
      return v;
   endfunction

   function automatic void expect_vec(input obs_t v, input string tag);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endfunction

   // Reference model: per-instruction cycle trace starting the cycle after the sampling edge.
   function automatic int push_model(input logic [31:0] ins, input string tag);
      obs_t       c = '0;
      obs_t       v;
      logic [5:0] op = ins[31:26];
      logic [4:0] fn = ins[4:0];
      bit         goes_mem = 0, writes = 0, halts = 0;
      int         busy;
      if (op == 0 && fn <= 6) begin
         writes = 1;
         if (fn == 0) c.alu_op = 2'b01;
         else if (fn == 1) begin c.alu_op = 2'b01; c.comp_enbl = 1; end
         else if (fn == 2) c.alu_op = 2'b10;
         else if (fn == 3) c.alu_op = 2'b11;
         else begin
            c.shift_enbl = 1; c.shift_amnt_sel = 1; c.shift_type = 2'(fn - 5'd4);
         end
      end else if (op == 1 || op == 2) begin
         writes = 1; c.alu_src = 1; c.alu_op = 2'b01; c.comp_enbl = (op == 2);
      end else if (op == 4 || op == 5) begin
         goes_mem = 1; writes = (op == 4);
         c.alu_src = 1; c.imm_sel = 1; c.alu_op = 2'b01;
         c.mem_to_reg = (op == 4) ? 2'b01 : 2'b00;
      end else if (op == 6) begin
         c.branch_reg = 1; c.jump_type = 2'b01;
      end else if (op == 7) begin
         c.long_br = 1; c.jump_type = 2'b01;
      end else if (op == 8) begin
         c.short_br = 1; c.branch_type = fn[1:0];
      end else if (op == 9) begin
         writes = 1; c.long_br = 1; c.jump_type = 2'b10; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
      end else if (op == 63) begin
         halts = 1;
      end else begin
`ifdef CTRL_ILLEGAL_HALT_EN
         halts = 1;
`endif
      end
      expect_vec('0, {tag, ":decode"});
      expect_vec(c, {tag, ":exec"});
      busy = 2;
      if (halts) begin
         for (int i = 0; i < 10; i++) expect_vec(halt_vec(), {tag, ":halt"});
         return busy + 10;
      end
      if (goes_mem) begin
         v = c; v.mem_read = (op == 4); v.mem_write = (op == 5);
         expect_vec(v, {tag, ":mem"});
         busy++;
      end
      if (writes) begin
         v = c; v.reg_write = 1;
         expect_vec(v, {tag, ":wb"});
         busy++;
      end
      expect_vec(idle_vec(), {tag, ":refetch"});
      return busy;
   endfunction

   // Monitor: compares whenever the DUT is busy or an expectation is pending.
   initial begin
      obs_t  act;
      obs_t  exp_v;
      string tag;
      forever begin
         @(negedge clk);
         act = {fetch_req, halt, RegWrite, ImmSel, ALUSrc, CompEnbl, ShiftAmntSel, ShiftEnbl,
                ShortBr, LongBr, MemRead, MemWrite, BranchReg,
                ALUOp, RegDst, ShiftType, BranchType, JumpType, MemToReg};
         if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            n_checks++;
            if (act !== exp_v) begin
               n_fail++;
               $display("FAIL %s: outputs got %h expected %h at %0t", tag, act, exp_v, $time);
            end
         end else if (fetch_req !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_busy: fetch_req got %b expected 1 at %0t", fetch_req, $time);
         end
      end
   end

   task automatic run_instr(input logic [31:0] ins, input string tag);
      int busy;
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      busy        = push_model(ins, tag);
      instr       = $urandom;
      instr_valid = 1'($urandom_range(0, 1));
      for (int i = 0; i < busy; i++) begin
         @(posedge clk);
         #1;
         instr       = $urandom;
         instr_valid = (i < busy - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
   endtask

   task automatic run_halt(input logic [31:0] ins, input string tag);
      int busy;
      instr       = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      busy = push_model(ins, tag);
      for (int i = 0; i < busy; i++) begin
         instr = $urandom;
         @(posedge clk);
         #1;
      end
      rst         = 1'b1;
      instr_valid = 1'b0;
      expect_vec(idle_vec(), {tag, ":reset"});
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] fn);
      logic [31:0] w;
      w        = $urandom;
      w[31:26] = op;
      w[4:0]   = fn;
      return w;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [5:0] legal [9];
      logic [5:0] op;
      logic [4:0] fn;
      int         pick;
      int         v;
      legal = '{6'd0, 6'd1, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9};
      fn    = 5'($urandom);
`ifdef CTRL_ILLEGAL_HALT_EN
      pick = $urandom_range(0, 8);
      if (pick == 0) fn = 5'($urandom_range(0, 6));
`else
      pick = $urandom_range(0, 9);
`endif
      if (pick < 9) begin
         op = legal[pick];
      end else begin
         v  = $urandom_range(0, 53);
         op = (v == 0) ? 6'd3 : 6'(v + 9);
      end
      return mk(op, fn);
   endfunction

   initial begin
      rst         = 1'b1;
      instr       = '0;
      instr_valid = 1'b0;
      expect_vec(idle_vec(), "reset_state");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      run_instr(mk(6'd1, 5'd0), "addi");
      run_instr(mk(6'd0, 5'd1), "comp");
      run_instr(mk(6'd0, 5'd3), "xor");
      run_instr(mk(6'd4, 5'd0), "lw");
      run_instr(mk(6'd5, 5'd0), "sw");
      run_instr(mk(6'd9, 5'd0), "bl");
      run_instr(mk(6'd8, 5'd2), "short_br");
      run_instr(mk(6'd0, 5'd5), "shift");
`ifndef CTRL_ILLEGAL_HALT_EN
      run_instr(mk(6'd0, 5'd9), "illegal_func_nop");
`endif
      for (int i = 0; i < 200; i++) run_instr(rand_instr(), "random");

      // Reset in the WB cycle of addi: RegWrite must drop right away.
      instr       = mk(6'd1, 5'd0);
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      begin
         obs_t c = '0;
         c.alu_src = 1'b1;
         c.alu_op  = 2'b01;
         expect_vec('0, "rst_wb:decode");
         expect_vec(c, "rst_wb:exec");
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      expect_vec(idle_vec(), "rst_wb:reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_instr(mk(6'd2, 5'd0), "compi_after_reset");

      run_halt(mk(6'd63, 5'd0), "halt_op");
`ifdef CTRL_ILLEGAL_HALT_EN
      run_halt(mk(6'd0, 5'd9), "illegal_func_halt");
`endif
      run_instr(mk(6'd0, 5'd2), "and_after_halt");

      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: pending expectations got %0d expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
